// File: rtl/svd_ctrl_pkg.sv
// Shared constants and state encoding for the SVD rotation controllers.
// Imported by the CORDIC schedulers and their iteration counter.
package svd_ctrl_pkg;

  localparam int N_ITER_DEF = 12;
  localparam int SHIFT_W    = 4;
  localparam int INDEX_W    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_WB,
    S_FIN
  } ctrl_state_e;

endpackage

// File: rtl/cordic_iter_cnt.sv
// CORDIC micro-iteration counter shared by the SVD controllers.
// Clear has priority over enable; last flags the final iteration.
module cordic_iter_cnt
  import svd_ctrl_pkg::*;
#(
  parameter int WIDTH  = SHIFT_W,
  parameter int N_ITER = N_ITER_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  localparam logic [WIDTH-1:0] LastCnt = WIDTH'(N_ITER - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign last  = (cnt_q == LastCnt);

endmodule

// File: rtl/cordic_rot_sched.sv
// Sweeps CORDIC rotations over a range of row pairs.
// Every output decodes flops only, so inputs never reach outputs.
module cordic_rot_sched
  import svd_ctrl_pkg::*;
#(
  parameter int WIDTH_SHIFT_BIT = SHIFT_W,
  parameter int WIDTH_INDEX     = INDEX_W,
  parameter int N_ITER          = N_ITER_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIDTH_INDEX-1:0]     first_idx,
  input  logic [WIDTH_INDEX-1:0]     last_idx,
  output logic [WIDTH_INDEX-1:0]     index,
  output logic                       ce0,
  output logic                       ce1,
  output logic                       sel,
  output logic [WIDTH_SHIFT_BIT-1:0] shift,
  output logic [WIDTH_SHIFT_BIT-1:0] count,
  output logic                       wb_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  ctrl_state_e            state_q;
  ctrl_state_e            state_d;
  logic [WIDTH_INDEX-1:0] index_q;
  logic [WIDTH_INDEX-1:0] index_d;
  logic [WIDTH_INDEX-1:0] last_q;
  logic [WIDTH_INDEX-1:0] last_d;
  logic                   err_q;
  logic                   err_d;
  logic                   cnt_clr;
  logic                   cnt_en;
  logic                   cnt_last;
  logic                   active;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      index_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (first_idx > last_idx) begin
              state_d = S_FIN;
              err_d   = 1'b1;
            end else begin
              state_d = S_LOAD;
              index_d = first_idx;
              last_d  = last_idx;
            end
          end
        end
        S_LOAD: state_d = S_ITER;
        S_ITER: begin
          if (cnt_last) begin
            state_d = S_WB;
          end
        end
        S_WB: begin
          // compare before incrementing so last=max never wraps
          if (index_q < last_q) begin
            index_d = index_q + 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_FIN;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          index_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          index_d = '0;
        end
      endcase
    end
  end

  assign cnt_clr = (state_d == S_IDLE) ||
                   (state_d == S_LOAD) ||
                   (state_d == S_FIN);
  assign cnt_en  = (state_d == S_ITER);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      index_q <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  cordic_iter_cnt #(
    .WIDTH  (WIDTH_SHIFT_BIT),
    .N_ITER (N_ITER)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .last  (cnt_last)
  );

  assign active   = (state_q == S_LOAD) ||
                    (state_q == S_ITER);
  assign index    = index_q;
  assign ce0      = active & ~index_q[WIDTH_INDEX-1];
  assign ce1      = active &  index_q[WIDTH_INDEX-1];
  assign sel      = (state_q == S_ITER);
  assign shift    = count;
  assign wb_valid = (state_q == S_WB);
  assign busy     = active | (state_q == S_WB);
  assign done     = (state_q == S_FIN);
  assign err      = err_q;

endmodule
